// File: rtl/merge_run_sequencer.sv
// merge_run_sequencer
//   Two-way stable merge of two ascending sorted runs (A, B) of programmed
//   lengths into one ascending stream. The smaller head wins and ties go to A.
//   When one run is exhausted, the other run is drained. The final element
//   is tagged with out_last, and completion is signalled with a one-cycle
//   done pulse.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   start, len_a, len_b merge request and run lengths (sampled in IDLE only)
//   a_data/a_valid/a_ready   run A head (FIFO read port; a_ready pops)
//   b_data/b_valid/b_ready   run B head (FIFO read port; b_ready pops)
//   out_data/out_valid/out_last/out_ready   registered merged output
//   busy                high whenever the sequencer is not idle
//   done                one-cycle completion pulse
//   state_dbg           current FSM state (debug observation)
//
// Handshake: a transfer happens on a rising edge where valid && ready.
//   On the input side, ready means "pop": it is combinational. It is raised
//   only for a side that is valid and being consumed this cycle. On the
//   output side, out_data/out_last hold while out_valid && !out_ready.
module merge_run_sequencer #(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [LEN_W-1:0]  len_a,
   input  logic [LEN_W-1:0]  len_b,
   input  logic [DATA_W-1:0] a_data,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [DATA_W-1:0] b_data,
   input  logic              b_valid,
   output logic              b_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              out_last,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output logic [2:0]        state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_MERGE   = 3'd1,
      S_DRAIN_A = 3'd2,
      S_DRAIN_B = 3'd3,
      S_FLUSH   = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t             state, state_nxt;
   logic [LEN_W-1:0]   cnt_a, cnt_b;
   logic [LEN_W:0]     cnt_sum;
   logic               can_load;
   logic               take_a;
   logic               fire;
   logic [DATA_W-1:0]  fire_data;
   logic               fire_last;

   // Single output register: it can take a new element when empty or when
   // its current element is being consumed this cycle.
   assign can_load = !out_valid || out_ready;

   // Unsigned compare; "<=" keeps equal keys in A-first order (stable merge).
   assign take_a = (a_data <= b_data);

   assign fire      = a_ready || b_ready;
   assign fire_data = a_ready ? a_data : b_data;

   // The element being popped is the last one when exactly one remains
   // across both runs. The extra bit keeps the sum from wrapping.
   assign cnt_sum   = {1'b0, cnt_a} + {1'b0, cnt_b};
   assign fire_last = (cnt_sum == (LEN_W + 1)'(1));

   assign state_dbg = state;

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (len_a != '0 && len_b != '0) state_nxt = S_MERGE;
               else if (len_a != '0)           state_nxt = S_DRAIN_A;
               else if (len_b != '0)           state_nxt = S_DRAIN_B;
               else                            state_nxt = S_FLUSH;
            end
         end
         S_MERGE: begin
            if (a_ready && cnt_a == LEN_W'(1)) begin
               state_nxt = (cnt_b == '0) ? S_FLUSH : S_DRAIN_B;
            end else if (b_ready && cnt_b == LEN_W'(1)) begin
               state_nxt = S_DRAIN_A;
            end
         end
         S_DRAIN_A: begin
            if (a_ready && cnt_a == LEN_W'(1)) state_nxt = S_FLUSH;
         end
         S_DRAIN_B: begin
            if (b_ready && cnt_b == LEN_W'(1)) state_nxt = S_FLUSH;
         end
         S_FLUSH: begin
            if (can_load) state_nxt = S_DONE;
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------- outputs
   // A drain side never looks at the other side's valid. Both readies stay
   // low outside MERGE/DRAIN and whenever the output register is blocked.
   always_comb begin
      a_ready = 1'b0;
      b_ready = 1'b0;
      case (state)
         S_MERGE: begin
            if (a_valid && b_valid && can_load) begin
               a_ready = take_a;
               b_ready = !take_a;
            end
         end
         S_DRAIN_A: a_ready = a_valid && can_load;
         S_DRAIN_B: b_ready = b_valid && can_load;
         default: begin
            a_ready = 1'b0;
            b_ready = 1'b0;
         end
      endcase
      busy = (state != S_IDLE);
      done = (state == S_DONE);
   end

   // ---------------------------------------------------------------- run counters
   // A pop only happens in a state that implies a nonzero count, so the
   // decrements cannot underflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_a <= '0;
         cnt_b <= '0;
      end else if (state == S_IDLE) begin
         if (start) begin
            cnt_a <= len_a;
            cnt_b <= len_b;
         end
      end else begin
         if (a_ready) cnt_a <= cnt_a - LEN_W'(1);
         if (b_ready) cnt_b <= cnt_b - LEN_W'(1);
      end
   end

   // ---------------------------------------------------------------- output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (fire) begin
         out_data  <= fire_data;
         out_valid <= 1'b1;
         out_last  <= fire_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_merge_run_sequencer.sv
module tb_merge_run_sequencer;

   localparam int DATA_W = 32;
   localparam int LEN_W  = 16;
   localparam int W      = DATA_W + 1;   // {last, data}

   // ---------------------------------------------------------------- clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // ---------------------------------------------------------------- DUT
   logic              start;
   logic [LEN_W-1:0]  len_a, len_b;
   logic [DATA_W-1:0] a_data, b_data, out_data;
   logic              a_valid, a_ready, b_valid, b_ready;
   logic              out_valid, out_last, out_ready;
   logic              busy, done;
   logic [2:0]        state_dbg;

   merge_run_sequencer #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .len_a     (len_a),
      .len_b     (len_b),
      .a_data    (a_data),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .b_data    (b_data),
      .b_valid   (b_valid),
      .b_ready   (b_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done),
      .state_dbg (state_dbg)
   );

   // ---------------------------------------------------------------- bookkeeping
   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Runs as generated by a test, sources being drained, and scoreboard queues.
   logic [DATA_W-1:0] gen_a[$], gen_b[$];
   logic [DATA_W-1:0] src_a[$], src_b[$];
   logic [W-1:0]      exp_q[$];
   logic              exp_side_q[$];   // 0 = pop from A, 1 = pop from B

   int vmode = 0;       // 0: sources valid whenever they hold data, 1: random bubbles
   int rmode = 0;       // 0: out_ready=1, 1: random, 2: 3-cycle stall at first output
   int stall_left = 0;
   bit stall_done = 0;
   bit a_pop_seen = 0, b_pop_seen = 0;

   int done_seen = 0, done_cyc = 0, last_pop_cyc = 0, start_cyc = 0;
   int out_seen = 0, first_out_cyc = -1, last_out_cyc = 0, out_cnt = 0;

   // ---------------------------------------------------------------- reference model
   // A plain stable two-way merge of the generated runs. It records each
   // output element together with its last flag, and which run supplies
   // each element.
   task automatic build_model();
      int i = 0;
      int j = 0;
      int n;
      bit use_a;
      n = gen_a.size() + gen_b.size();
      exp_q.delete();
      exp_side_q.delete();
      for (int k = 0; k < n; k++) begin
         if (j >= gen_b.size())      use_a = 1'b1;
         else if (i >= gen_a.size()) use_a = 1'b0;
         else                        use_a = (gen_a[i] <= gen_b[j]);
         if (use_a) begin
            exp_q.push_back({(k == n - 1), gen_a[i]});
            exp_side_q.push_back(1'b0);
            i++;
         end else begin
            exp_q.push_back({(k == n - 1), gen_b[j]});
            exp_side_q.push_back(1'b1);
            j++;
         end
      end
   endtask

   task automatic gen_run(input int n, input logic [DATA_W-1:0] base, output logic [DATA_W-1:0] q[$]);
      logic [DATA_W-1:0] v;
      q.delete();
      v = base;
      for (int i = 0; i < n; i++) begin
         q.push_back(v);
         if ($urandom_range(0, 3) != 0) v = v + DATA_W'($urandom_range(1, 1000));
      end
   endtask

   // ---------------------------------------------------------------- driver
   // Inputs change 1 time unit after each rising edge. A pop seen at the
   // preceding falling edge removes the head of that source.
   initial begin
      start = 1'b0; len_a = '0; len_b = '0;
      a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (a_pop_seen && src_a.size() > 0) void'(src_a.pop_front());
         if (b_pop_seen && src_b.size() > 0) void'(src_b.pop_front());
         a_pop_seen = 1'b0;
         b_pop_seen = 1'b0;
         a_valid = (src_a.size() > 0) && (vmode == 0 || $urandom_range(0, 1) == 1);
         b_valid = (src_b.size() > 0) && (vmode == 0 || $urandom_range(0, 1) == 1);
         a_data  = (src_a.size() > 0) ? src_a[0] : DATA_W'($urandom);
         b_data  = (src_b.size() > 0) ? src_b[0] : DATA_W'($urandom);
         if (rmode == 2 && !stall_done && out_valid) begin
            stall_left = 3;
            stall_done = 1'b1;
         end
         if (rmode == 0)      out_ready = 1'b1;
         else if (rmode == 1) out_ready = ($urandom_range(0, 2) != 0);
         else                 out_ready = (stall_left == 0);
         if (stall_left > 0) stall_left--;
      end
   end

   // ---------------------------------------------------------------- monitor / scoreboard
   bit           prev_stall = 1'b0;
   logic [W-1:0] held;

   initial begin
      logic [W-1:0] e;
      logic         s;
      bit           viol;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            // Ready rules: exclusive, only while busy and not in the done
            // cycle, never into a blocked output register, never to an
            // invalid side.
            if (busy || a_ready || b_ready) begin
               viol = (a_ready && b_ready)
                   || ((a_ready || b_ready) && (!busy || done || (out_valid && !out_ready)))
                   || (a_ready && !a_valid) || (b_ready && !b_valid);
               chk("ready_rules", viol, 1'b0);
            end
            if (a_ready || b_ready) begin
               a_pop_seen   = a_ready;
               b_pop_seen   = b_ready;
               last_pop_cyc = cyc;
               if (exp_side_q.size() == 0) begin
                  chk("pop_extra", 1'b1, 1'b0);
               end else begin
                  s = exp_side_q.pop_front();
                  chk("pop_side", b_ready, s);
               end
            end
            if (prev_stall) begin
               chk("hold_valid", out_valid, 1'b1);
               chk("hold_data", {out_last, out_data}, held);
            end
            prev_stall = out_valid && !out_ready;
            held       = {out_last, out_data};
            if (out_valid) out_seen++;
            if (out_valid && out_ready) begin
               if (first_out_cyc < 0) first_out_cyc = cyc;
               last_out_cyc = cyc;
               out_cnt++;
               if (exp_q.size() == 0) begin
                  chk("out_extra", {out_last, out_data}, '0);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_elem", {out_last, out_data}, e);
               end
            end
            if (done) begin
               done_seen++;
               done_cyc = cyc;
            end
         end
      end
   end

   // ---------------------------------------------------------------- merge transaction
   task automatic do_merge(input int vm, input int rm, input bit second_start,
                           input bit mid_reset, input bit check_drain);
      int  base_done;
      bit  got;
      build_model();
      vmode = vm; rmode = rm; stall_done = 1'b0; stall_left = 0;
      src_a = gen_a; src_b = gen_b;
      out_seen = 0; out_cnt = 0; first_out_cyc = -1;
      base_done = done_seen;
      @(posedge clk); #1;
      start = 1'b1;
      len_a = LEN_W'(gen_a.size());
      len_b = LEN_W'(gen_b.size());
      start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      len_a = LEN_W'($urandom);
      len_b = LEN_W'($urandom);
      if (check_drain) begin
         for (int t = 0; t < 50 && !out_valid; t++) begin
            @(posedge clk); #1;
         end
         chk("first_out_data", out_data, 1);
         chk("drain_b_state", state_dbg, 3'd3);
      end
      if (second_start) begin
         repeat (2) @(posedge clk);
         #1;
         chk("busy_in_merge", busy, 1'b1);
         chk("merge_state", state_dbg, 3'd1);
         start = 1'b1; len_a = 1; len_b = 1;
         @(posedge clk); #1;
         start = 1'b0;
      end
      if (mid_reset) begin
         repeat (2) @(posedge clk);
         #2;
         chk("pre_reset_valid", out_valid, 1'b1);
         rst_n = 1'b0;
         #1;
         chk("rst_out_valid", out_valid, 1'b0);
         chk("rst_busy", busy, 1'b0);
         chk("rst_readies", {a_ready, b_ready}, 2'b00);
         src_a.delete(); src_b.delete();
         exp_q.delete(); exp_side_q.delete();
         repeat (2) @(posedge clk);
         #2;
         rst_n = 1'b1;
         return;
      end
      got = 1'b0;
      for (int t = 0; t < 3000 && !got; t++) begin
         @(posedge clk);
         if (done_seen != base_done) got = 1'b1;
      end
      chk("done_timeout", got, 1'b1);
      #1;
      chk("all_out_seen", exp_q.size(), 0);
      chk("all_pops_seen", exp_side_q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
      chk("done_once", done_seen - base_done, 1);
      chk("idle_after", busy, 1'b0);
   endtask

   // ---------------------------------------------------------------- tests
   initial begin
      logic [DATA_W-1:0] base_a, base_b;
      repeat (3) @(posedge clk);
      #1;
      // reset state
      chk("rst_out_valid0", out_valid, 1'b0);
      chk("rst_out_last0", out_last, 1'b0);
      chk("rst_out_data0", out_data, '0);
      chk("rst_done0", done, 1'b0);
      chk("rst_busy0", busy, 1'b0);
      chk("rst_state0", state_dbg, 3'd0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // basic interleave
      gen_a = '{3, 241, 3524};
      gen_b = '{242, 3532};
      do_merge(0, 0, 0, 0, 0);
      chk("basic_out_cnt", out_cnt, 5);
      chk("basic_consecutive", last_out_cyc - first_out_cyc, 4);
      chk("basic_done_gap", done_cyc - last_pop_cyc, 2);

      // ties stay in A-first order
      gen_a = '{5, 5};
      gen_b = '{5};
      do_merge(0, 0, 0, 0, 0);
      chk("tie_out_cnt", out_cnt, 3);

      // A exhausted during a 3-cycle output stall, then drain B
      gen_a = '{1};
      gen_b = '{10, 20, 30};
      do_merge(0, 2, 0, 0, 1);
      chk("stall_out_cnt", out_cnt, 4);

      // empty A, B with bubbles
      gen_a.delete();
      gen_b = '{77, 78};
      do_merge(1, 0, 0, 0, 0);
      chk("b_only_out_cnt", out_cnt, 2);

      // zero-length merge
      gen_a.delete();
      gen_b.delete();
      do_merge(0, 0, 0, 0, 0);
      chk("zero_done_lat", done_cyc - start_cyc, 2);
      chk("zero_no_valid", out_seen, 0);

      // second start while merging is ignored
      gen_run(6, 100, gen_a);
      gen_run(6, 100, gen_b);
      do_merge(0, 0, 1, 0, 0);
      chk("restart_out_cnt", out_cnt, 12);

      // reset mid-merge, then a fresh merge
      gen_run(8, 10, gen_a);
      gen_run(8, 10, gen_b);
      do_merge(0, 0, 0, 1, 0);
      gen_run(3, 500, gen_a);
      gen_run(4, 400, gen_b);
      do_merge(0, 0, 0, 0, 0);
      chk("post_reset_cnt", out_cnt, 7);

      // randomized merges, including values with the top bit set
      for (int r = 0; r < 24; r++) begin
         base_a = ($urandom_range(0, 1) == 1) ? DATA_W'(32'h8000_0000 + $urandom_range(0, 5000))
                                             : DATA_W'($urandom_range(0, 5000));
         base_b = ($urandom_range(0, 1) == 1) ? DATA_W'(32'h8000_0000 + $urandom_range(0, 5000))
                                             : DATA_W'($urandom_range(0, 5000));
         gen_run($urandom_range(0, 10), base_a, gen_a);
         gen_run($urandom_range(0, 10), base_b, gen_b);
         do_merge($urandom_range(0, 1), $urandom_range(0, 1), 0, 0, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: got=timeout expected=finish");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/merge_run_sequencer.md
Name: merge_run_sequencer

Overview:
- Sequences a two-way merge of two ascending sorted runs (A, B) of programmed lengths into one ascending output stream.
- Performs the compare/select step inline: the smaller head wins; ties go to A, so the merge is stable.
- Sits between two run buffers (FIFO read ports) and the downstream merge-tree stage or write-back.
- Handles run exhaustion by draining the other side, supports output back-pressure, and marks the last element and completion.

Parameters:
- DATA_W, 32, element width (unsigned compare).
- LEN_W, 16, run-length counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a merge; sampled in IDLE only.
- len_a  in  LEN_W  element count of run A, latched on accepted start.
- len_b  in  LEN_W  element count of run B, latched on accepted start.
- a_data  in  DATA_W  head of run A.
- a_valid  in  1  a_data valid.
- a_ready  out  1  pop A this cycle (combinational).
- b_data  in  DATA_W  head of run B.
- b_valid  in  1  b_data valid.
- b_ready  out  1  pop B this cycle (combinational).
- out_data  out  DATA_W  registered merged element.
- out_valid  out  1  out_data valid.
- out_last  out  1  qualifies out_data as final element of the merge.
- out_ready  in  1  downstream accepts out_data.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, any state, mid-merge included):
  - state=IDLE; counters cleared.
  - out_valid=0, out_last=0, out_data=0, done=0, busy=0.
  - Any in-flight element is discarded.
- Load condition: can_load = !out_valid || out_ready (single output register, full throughput).
- States:
  - IDLE: start=1 latches cnt_a=len_a and cnt_b=len_b.
    - Both counts nonzero -> MERGE.
    - Only cnt_a nonzero -> DRAIN_A.
    - Only cnt_b nonzero -> DRAIN_B.
    - Both zero -> FLUSH.
    - start is ignored in every state other than IDLE.
  - MERGE:
    - Fires only when a_valid && b_valid && can_load.
    - Selects A if a_data <= b_data, else B.
    - Asserts the selected side's ready in that cycle only; the other ready stays 0.
    - Decrements the selected counter.
    - When cnt_a reaches 0 -> DRAIN_B, or FLUSH if cnt_b == 0.
    - When cnt_b reaches 0 -> DRAIN_A.
  - DRAIN_A / DRAIN_B:
    - Fires when <side>_valid && can_load.
    - Passes the head through, asserts that side's ready, and decrements its counter.
    - When the counter reaches 0 -> FLUSH.
    - The opposite ready is held at 0.
  - FLUSH: waits until the output register is empty or being consumed (!out_valid || out_ready), then -> DONE.
  - DONE: done=1 for exactly one cycle, then -> IDLE.
- Ready rule: a_ready and b_ready are never both 1, and are 0 whenever can_load=0 or the state is IDLE, FLUSH or DONE.
- Output register:
  - A fire loads out_data and sets out_valid=1 at the next edge, i.e. 1-cycle latency from the pop.
  - out_last=1 when cnt_a+cnt_b == 1 before the decrement.
  - With no fire and out_ready=1, out_valid clears.
  - While out_valid && !out_ready, out_data and out_last are held stable.
- Comparison is full-width unsigned; counters never underflow (a fire requires a nonzero count).
- Neither the counters nor the ready outputs depend on input valid from the side not being consumed.
- Zero-length merge (len_a = len_b = 0):
  - No output element is produced.
  - start at cycle N -> FLUSH at N+1 -> done=1 at N+2.

Test Plan:
- Basic interleave: A={3,241,3524}, B={242,3532}, out_ready=1, both sides always valid.
  - Output 3, 241, 242, 3524, 3532 on consecutive cycles.
  - out_last only on 3532; done is 2 cycles after the last pop.
- Tie/stability: A={5,5}, B={5}.
  - Pops in order A, A, B, each pop followed one cycle later by output 5.
  - a_ready asserted on the first two fires.
- Exhaustion and back-pressure: A={1}, B={10,20,30}, out_ready low for 3 cycles after the first output.
  - out_data=1 is held stable, no pops occur during the stall, and the sequencer enters DRAIN_B.
  - Output completes as 1, 10, 20, 30.
- Bubbles and edge lengths:
  - len_a=0, len_b=2 with b_valid toggling -> only b_ready ever asserted, output is B verbatim.
  - len_a=len_b=0 -> done 2 cycles after start, out_valid never asserted.
- Start while busy, then reset:
  - A second start pulse during MERGE is ignored and the counts are unchanged.
  - Asserting rst_n=0 mid-MERGE immediately clears out_valid and busy.
  - A fresh start after reset release merges correctly.
